// File: rtl/smg_display_arbiter.sv
// Two-source arbiter for a 4-digit 7-segment display: source A (alarm) has priority
// and may preempt, source B (status) gets the display once A's minimum lock expires.
module smg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 25_000_000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Req_A,
  input  logic [15:0] Data_A,
  output logic        Ack_A,
  input  logic        Req_B,
  input  logic [15:0] Data_B,
  output logic        Ack_B,
  output logic [15:0] Number_Sig,
  output logic [1:0]  Source_Sig
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOCK_A = 2'b01,
    LOCK_B = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             elig_a;
  logic             elig_b;
  logic             take_a;
  logic             take_b;

  // A request seen while its own Ack is high is the tail of the one just accepted.
  assign elig_a = Req_A && !Ack_A;
  assign elig_b = Req_B && !Ack_B;

  always_comb begin
    take_a = 1'b0;
    take_b = 1'b0;
    case (state)
      IDLE: begin
        take_a = elig_a;
        take_b = !elig_a && elig_b;
      end
      LOCK_A: begin
        take_a = elig_a;
        take_b = !elig_a && elig_b && (cnt == '0);
      end
      LOCK_B: begin
        take_a = elig_a;
        take_b = !elig_a && elig_b;
      end
      default: begin
        take_a = 1'b0;
        take_b = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= IDLE;
      cnt        <= '0;
      Number_Sig <= '0;
      Source_Sig <= '0;
      Ack_A      <= 1'b0;
      Ack_B      <= 1'b0;
    end else begin
      Ack_A <= take_a;
      Ack_B <= take_b;
      if (take_a) begin
        state      <= LOCK_A;
        cnt        <= RELOAD;
        Number_Sig <= Data_A;
        Source_Sig <= 2'b01;
      end else if (take_b) begin
        state      <= LOCK_B;
        cnt        <= RELOAD;
        Number_Sig <= Data_B;
        Source_Sig <= 2'b10;
      end else if (state != IDLE) begin
        if (cnt == '0) begin
          state <= IDLE;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_smg_display_arbiter.sv
// Directed bench for smg_display_arbiter with a 4-clock lock; expected values are
// worked out edge by edge alongside each scenario.
module tb_smg_display_arbiter;

  logic        CLK;
  logic        RSTn;
  logic        Req_A;
  logic [15:0] Data_A;
  logic        Ack_A;
  logic        Req_B;
  logic [15:0] Data_B;
  logic        Ack_B;
  logic [15:0] Number_Sig;
  logic [1:0]  Source_Sig;

  int unsigned checks;
  int unsigned errors;

  smg_display_arbiter #(.HOLD_CYCLES(4)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Req_A      (Req_A),
    .Data_A     (Data_A),
    .Ack_A      (Ack_A),
    .Req_B      (Req_B),
    .Data_B     (Data_B),
    .Ack_B      (Ack_B),
    .Number_Sig (Number_Sig),
    .Source_Sig (Source_Sig)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] num, input logic [1:0] src,
                           input logic ack_a, input logic ack_b);
    check({tag, ".num"},   Number_Sig,         num);
    check({tag, ".src"},   {14'b0, Source_Sig}, {14'b0, src});
    check({tag, ".ack_a"}, {15'b0, Ack_A},      {15'b0, ack_a});
    check({tag, ".ack_b"}, {15'b0, Ack_B},      {15'b0, ack_b});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RSTn   = 1'b0;
    Req_A  = 1'b0;
    Req_B  = 1'b0;
    Data_A = 16'h0000;
    Data_B = 16'h0000;
    tick();
    tick();
    check_out("reset", 16'h0000, 2'b00, 1'b0, 1'b0);
    check("reset.state", 16'(dut.state), 16'd0);

    // B alone from IDLE: accept, one-cycle Ack, back to IDLE after 4 lock cycles.
    RSTn   = 1'b1;
    Req_B  = 1'b1;
    Data_B = 16'h1234;
    tick();
    Req_B = 1'b0;
    check_out("b_accept", 16'h1234, 2'b10, 1'b0, 1'b1);
    tick();
    check_out("b_ack_drop", 16'h1234, 2'b10, 1'b0, 1'b0);
    tick();
    tick();
    check("b_lock_last", 16'(dut.state), 16'd2);
    tick();
    check("b_idle", 16'(dut.state), 16'd0);
    check_out("b_idle_hold", 16'h1234, 2'b10, 1'b0, 1'b0);

    // Simultaneous requests in IDLE: A first, B exactly 4 cycles after Ack_A.
    Req_A  = 1'b1;
    Data_A = 16'h9999;
    Req_B  = 1'b1;
    Data_B = 16'h0001;
    tick();
    Req_A = 1'b0;
    check_out("both_a", 16'h9999, 2'b01, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_out($sformatf("both_wait%0d", i), 16'h9999, 2'b01, 1'b0, 1'b0);
    end
    tick();
    Req_B = 1'b0;
    check_out("both_b", 16'h0001, 2'b10, 1'b0, 1'b1);

    // LOCK_B: new B accepted immediately, then A preempts immediately.
    tick();
    Req_B  = 1'b1;
    Data_B = 16'h0042;
    tick();
    Req_B = 1'b0;
    check_out("lockb_b", 16'h0042, 2'b10, 1'b0, 1'b1);
    tick();
    Req_A  = 1'b1;
    Data_A = 16'h0911;
    tick();
    Req_A = 1'b0;
    check_out("preempt_a", 16'h0911, 2'b01, 1'b1, 1'b0);

    // LOCK_A: held B waits out the lock; non-BCD data passes untouched.
    Req_B  = 1'b1;
    Data_B = 16'hBEEF;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_out($sformatf("locka_wait%0d", i), 16'h0911, 2'b01, 1'b0, 1'b0);
    end
    tick();
    Req_B = 1'b0;
    check_out("locka_b", 16'hBEEF, 2'b10, 1'b0, 1'b1);

    // Req_A held: Ack_A every second cycle, owner stays A.
    Req_A  = 1'b1;
    Data_A = 16'hA5A5;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_out($sformatf("a_held%0d", i), 16'hA5A5, 2'b01, (i % 2) == 0, 1'b0);
    end
    Data_A = 16'h5678;
    tick();
    Req_A = 1'b0;
    check_out("a_5678", 16'h5678, 2'b01, 1'b1, 1'b0);

    // Reset mid-lock with B pending, then B arbitrated afresh.
    Req_B  = 1'b1;
    Data_B = 16'hCAFE;
    tick();
    check_out("pre_rst", 16'h5678, 2'b01, 1'b0, 1'b0);
    RSTn = 1'b0;
    tick();
    check_out("mid_rst", 16'h0000, 2'b00, 1'b0, 1'b0);
    check("mid_rst.state", 16'(dut.state), 16'd0);
    RSTn = 1'b1;
    tick();
    Req_B = 1'b0;
    check_out("post_rst_b", 16'hCAFE, 2'b10, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
